mdu_scheduler: RTL and testbench
================================

Name: mdu_scheduler

Overview:
- Sequences the multi-cycle multiplier and divider on behalf of the decode stage.
- Accepts one-cycle start requests from control and launches the unit with a single-cycle go pulse.
- Holds the pipeline stalled until the unit reports done, then issues one register-file writeback (integer or FP file, destination latched at start).
- Provides a timeout watchdog and a flush path so a hung or cancelled operation cannot lock the core.

Parameters:
- TIMEOUT, 64, maximum WAIT-state cycles before abort; legal range 2..2^CNT_W-1
- CNT_W, 7, width of the busy-cycle counter

Ports:
- clk  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- mult_start  in  1  multiply request from control, sampled only in IDLE
- div_start  in  1  divide request from control, sampled only in IDLE
- mult_mode  in  2  multiply variant, latched on accept
- div_mode  in  1  signed/unsigned divide, latched on accept
- dest_reg  in  5  destination register, latched on accept
- dest_fp  in  1  1 = destination in FP register file, latched on accept
- multiplier_done  in  1  multiplier result valid
- divider_done  in  1  divider result valid
- flush  in  1  cancel in-flight operation
- mult_go  out  1  one-cycle launch pulse to multiplier
- div_go  out  1  one-cycle launch pulse to divider
- mult_mode_q  out  2  latched mult_mode
- div_mode_q  out  1  latched div_mode
- stall  out  1  hold decode/fetch
- wb_en  out  1  one-cycle register write strobe
- wb_reg  out  5  latched destination
- wb_fp  out  1  latched dest_fp
- wb_sel  out  1  0 = multiplier result, 1 = divider result
- busy_cycles  out  CNT_W  cycles spent in the current WAIT state
- timeout  out  1  sticky abort flag
- conflict  out  1  sticky flag for simultaneous starts

Behaviour:
- States: IDLE, MUL_WAIT, DIV_WAIT, WB. Encoding lives in the package.
- Reset (reset==0 at an edge):
  - State goes to IDLE.
  - All outputs clear to 0: latched fields, busy_cycles, timeout, conflict.
  - Reset overrides every other input, including mid-operation. No wb_en is issued.
- stall is combinational: (state != IDLE) || (state == IDLE && (mult_start || div_start) && !flush). Decode freezes in the request cycle itself.
- IDLE:
  - mult_start: latch fields; next state MUL_WAIT.
  - div_start only: latch fields; next state DIV_WAIT.
  - Both asserted: multiply wins, the divide request is dropped, conflict is set.
  - flush in IDLE suppresses acceptance.
  - done inputs are ignored in IDLE.
- Entry to a WAIT state:
  - mult_go or div_go is high for exactly the first WAIT cycle.
  - busy_cycles resets to 0 on entry and increments each WAIT cycle, saturating at TIMEOUT.
- MUL_WAIT / DIV_WAIT:
  - The matching done input, sampled in any WAIT cycle including the go cycle, moves to WB.
  - The non-matching done input is ignored.
  - If busy_cycles == TIMEOUT-1 and done is still absent: set timeout, go to IDLE, no writeback.
  - done in that same cycle takes priority over timeout and moves to WB.
- WB:
  - wb_en = 1 for one cycle with wb_reg, wb_fp and wb_sel held stable; stall stays 1.
  - Next state is IDLE. A new start can be accepted in the cycle after WB.
- flush in MUL_WAIT, DIV_WAIT or WB:
  - Next state is IDLE; wb_en is forced to 0 in that cycle.
  - stall deasserts the cycle after flush.
  - A late done arriving in IDLE is ignored.
- Latched fields hold their value until the next accept and do not clear on return to IDLE.
- Latency: request cycle N, go in N+1, done at cycle D (D ≥ N+1), wb_en at D+1, stall low at D+2.

Decomposition:
- Shared constants header:
  - state encodings MDU_IDLE, MDU_MUL_WAIT, MDU_DIV_WAIT, MDU_WB
  - WB_SEL_MUL = 0, WB_SEL_DIV = 1
- Sub-module mdu_watchdog: the saturating busy counter and the timeout compare, with clear, enable and TIMEOUT inputs.
- The FSM and the latches stay in the top-level module.

Test Plan:
- Multiply: mult_start=1, dest_reg=5, dest_fp=0; multiplier_done 3 cycles after mult_go -> mult_go pulses once, stall is high for 6 cycles, wb_en is one pulse with wb_reg=5, wb_fp=0, wb_sel=0.
- Single-cycle divide: div_start=1, dest_reg=30, dest_fp=1; divider_done in the go cycle -> wb_en in the next cycle with wb_reg=30, wb_fp=1, wb_sel=1; stall is high for 3 cycles.
- Conflict: mult_start=div_start=1 -> only mult_go fires, conflict=1 and stays 1 until reset; div_go is never asserted.
- Timeout: TIMEOUT=8, no done -> timeout=1 after 8 WAIT cycles, return to IDLE, no wb_en; a later divider_done in IDLE produces nothing.
- Flush: flush 2 cycles after mult_go -> stall low in the next cycle, no wb_en; a new div_start is accepted immediately afterwards.
- Reset in DIV_WAIT at busy_cycles=4 -> next cycle all outputs are 0, state is IDLE, and no wb_en even if divider_done coincides.

Source files
------------

// File: rtl/mdu_scheduler_pkg.sv
// Shared definitions for the multiply/divide scheduler.
// Contents:
//   mdu_state_t      - FSM state encoding (IDLE, MUL_WAIT, DIV_WAIT, WB)
//   WB_SEL_MUL/DIV   - writeback source select values
//   mdu_is_wait()    - true when the FSM is waiting on a unit
package mdu_scheduler_pkg;

   typedef enum logic [1:0] {
      MDU_IDLE     = 2'd0,
      MDU_MUL_WAIT = 2'd1,
      MDU_DIV_WAIT = 2'd2,
      MDU_WB       = 2'd3
   } mdu_state_t;

   localparam logic WB_SEL_MUL = 1'b0;
   localparam logic WB_SEL_DIV = 1'b1;

   // A WAIT state is any state where the busy counter should run.
   function automatic logic mdu_is_wait(input mdu_state_t st);
      return (st == MDU_MUL_WAIT) || (st == MDU_DIV_WAIT);
   endfunction

endpackage

// File: rtl/mdu_watchdog.sv
// Busy-cycle counter and timeout compare for the multiply/divide scheduler.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-low reset
//   clear    in   restart the count at 0 (entry to a WAIT state)
//   enable   in   count this cycle (FSM is in a WAIT state)
//   count    out  cycles spent in the current WAIT state, saturates at TIMEOUT
//   expired  out  count has reached TIMEOUT-1 (last permitted WAIT cycle)
module mdu_watchdog #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             expired
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count_r;

   // Saturating busy counter; clear wins over enable.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_r <= '0;
      end else if (clear) begin
         count_r <= '0;
      end else if (enable && (count_r != LIMIT)) begin
         count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign count   = count_r;
   assign expired = (count_r == LAST);

endmodule

// File: rtl/mdu_scheduler.sv
// Multiply/divide scheduler: accepts a start request from control, launches
// the multiplier or divider with a one-cycle go pulse, stalls decode until the
// unit reports done, then issues a single register-file writeback.
// A watchdog aborts a hung operation and flush cancels an in-flight one.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   mult_start, div_start      start requests (sampled in IDLE only)
//   mult_mode, div_mode        operation variants, latched on accept
//   dest_reg, dest_fp          writeback destination, latched on accept
//   multiplier_done            multiplier result valid
//   divider_done               divider result valid
//   flush                      cancel in-flight operation / suppress accept
//   mult_go, div_go            one-cycle launch pulses
//   mult_mode_q, div_mode_q    latched variants
//   stall                      hold decode/fetch
//   wb_en, wb_reg, wb_fp       writeback strobe and destination
//   wb_sel                     0 = multiplier result, 1 = divider result
//   busy_cycles                cycles spent in the current WAIT state
//   timeout, conflict          sticky abort / simultaneous-start flags
module mdu_scheduler
   import mdu_scheduler_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mult_start,
   input  logic             div_start,
   input  logic [1:0]       mult_mode,
   input  logic             div_mode,
   input  logic [4:0]       dest_reg,
   input  logic             dest_fp,
   input  logic             multiplier_done,
   input  logic             divider_done,
   input  logic             flush,
   output logic             mult_go,
   output logic             div_go,
   output logic [1:0]       mult_mode_q,
   output logic             div_mode_q,
   output logic             stall,
   output logic             wb_en,
   output logic [4:0]       wb_reg,
   output logic             wb_fp,
   output logic             wb_sel,
   output logic [CNT_W-1:0] busy_cycles,
   output logic             timeout,
   output logic             conflict
);

   mdu_state_t state_r;
   mdu_state_t state_s;

   logic       accept_mul_s;
   logic       accept_div_s;
   logic       set_conflict_s;
   logic       set_timeout_s;
   logic       wd_expired_s;

   logic       mult_go_r;
   logic       div_go_r;
   logic [1:0] mult_mode_r;
   logic       div_mode_r;
   logic [4:0] wb_reg_r;
   logic       wb_fp_r;
   logic       wb_sel_r;
   logic       timeout_r;
   logic       conflict_r;

   mdu_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (accept_mul_s | accept_div_s),
      .enable  (mdu_is_wait(state_r)),
      .count   (busy_cycles),
      .expired (wd_expired_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= MDU_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic. Flush beats done, done beats the watchdog abort.
   always_comb begin
      state_s        = state_r;
      accept_mul_s   = 1'b0;
      accept_div_s   = 1'b0;
      set_conflict_s = 1'b0;
      set_timeout_s  = 1'b0;
      case (state_r)
         MDU_IDLE: begin
            if (flush) begin
               state_s = MDU_IDLE;
            end else if (mult_start) begin
               // Multiply wins a simultaneous request; the divide is dropped.
               accept_mul_s   = 1'b1;
               set_conflict_s = div_start;
               state_s        = MDU_MUL_WAIT;
            end else if (div_start) begin
               accept_div_s = 1'b1;
               state_s      = MDU_DIV_WAIT;
            end else begin
               state_s = MDU_IDLE;
            end
         end
         MDU_MUL_WAIT: begin
            if (flush) begin
               state_s = MDU_IDLE;
            end else if (multiplier_done) begin
               state_s = MDU_WB;
            end else if (wd_expired_s) begin
               set_timeout_s = 1'b1;
               state_s       = MDU_IDLE;
            end else begin
               state_s = MDU_MUL_WAIT;
            end
         end
         MDU_DIV_WAIT: begin
            if (flush) begin
               state_s = MDU_IDLE;
            end else if (divider_done) begin
               state_s = MDU_WB;
            end else if (wd_expired_s) begin
               set_timeout_s = 1'b1;
               state_s       = MDU_IDLE;
            end else begin
               state_s = MDU_DIV_WAIT;
            end
         end
         MDU_WB: begin
            state_s = MDU_IDLE;
         end
         default: begin
            state_s = MDU_IDLE;
         end
      endcase
   end

   // Go pulses, latched operation fields and sticky status flags.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mult_go_r   <= 1'b0;
         div_go_r    <= 1'b0;
         mult_mode_r <= 2'b00;
         div_mode_r  <= 1'b0;
         wb_reg_r    <= 5'd0;
         wb_fp_r     <= 1'b0;
         wb_sel_r    <= 1'b0;
         timeout_r   <= 1'b0;
         conflict_r  <= 1'b0;
      end else begin
         // Registered from the accept decision, so each go covers exactly the
         // first WAIT cycle.
         mult_go_r  <= accept_mul_s;
         div_go_r   <= accept_div_s;
         timeout_r  <= timeout_r | set_timeout_s;
         conflict_r <= conflict_r | set_conflict_s;
         if (accept_mul_s || accept_div_s) begin
            mult_mode_r <= mult_mode;
            div_mode_r  <= div_mode;
            wb_reg_r    <= dest_reg;
            wb_fp_r     <= dest_fp;
            wb_sel_r    <= accept_div_s ? WB_SEL_DIV : WB_SEL_MUL;
         end else begin
            mult_mode_r <= mult_mode_r;
            div_mode_r  <= div_mode_r;
            wb_reg_r    <= wb_reg_r;
            wb_fp_r     <= wb_fp_r;
            wb_sel_r    <= wb_sel_r;
         end
      end
   end

   // Stall covers the request cycle itself so decode freezes immediately;
   // a flush in the WB cycle cancels the write strobe.
   assign stall = (state_r != MDU_IDLE) ||
                  ((mult_start || div_start) && !flush);
   assign wb_en = (state_r == MDU_WB) && !flush;

   assign mult_go     = mult_go_r;
   assign div_go      = div_go_r;
   assign mult_mode_q = mult_mode_r;
   assign div_mode_q  = div_mode_r;
   assign wb_reg      = wb_reg_r;
   assign wb_fp       = wb_fp_r;
   assign wb_sel      = wb_sel_r;
   assign timeout     = timeout_r;
   assign conflict    = conflict_r;

endmodule

// File: tb/tb_mdu_scheduler.sv
// Self-checking bench for mdu_scheduler. Each operation is described as a
// transaction (unit, destination, done cycle, flush cycle) and the expected
// per-cycle outputs are derived from that description with plain arithmetic.
module tb_mdu_scheduler;

   localparam int TO = 8;
   localparam int CW = 7;

   logic          clk = 1'b0;
   logic          reset;
   logic          mult_start, div_start;
   logic [1:0]    mult_mode;
   logic          div_mode;
   logic [4:0]    dest_reg;
   logic          dest_fp;
   logic          multiplier_done, divider_done, flush;
   logic          mult_go, div_go;
   logic [1:0]    mult_mode_q;
   logic          div_mode_q;
   logic          stall, wb_en;
   logic [4:0]    wb_reg;
   logic          wb_fp, wb_sel;
   logic [CW-1:0] busy_cycles;
   logic          timeout, conflict;

   int n_vec = 0;
   int n_err = 0;
   logic exp_conflict = 1'b0;
   logic exp_timeout  = 1'b0;

   always #5 clk = ~clk;

   mdu_scheduler #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .mult_start(mult_start), .div_start(div_start),
      .mult_mode(mult_mode), .div_mode(div_mode),
      .dest_reg(dest_reg), .dest_fp(dest_fp),
      .multiplier_done(multiplier_done), .divider_done(divider_done),
      .flush(flush),
      .mult_go(mult_go), .div_go(div_go),
      .mult_mode_q(mult_mode_q), .div_mode_q(div_mode_q),
      .stall(stall), .wb_en(wb_en), .wb_reg(wb_reg), .wb_fp(wb_fp),
      .wb_sel(wb_sel), .busy_cycles(busy_cycles),
      .timeout(timeout), .conflict(conflict)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_inputs();
      mult_start = 1'b0; div_start = 1'b0;
      multiplier_done = 1'b0; divider_done = 1'b0; flush = 1'b0;
   endtask

   // One idle cycle: nothing may be launched or written, flags are sticky.
   task automatic check_idle(input string tag, input bit late_done);
      clr_inputs();
      dest_reg = 5'($urandom);
      multiplier_done = late_done ? 1'($urandom) : 1'b0;
      divider_done    = late_done;
      @(negedge clk);
      chk({tag, ".stall"},    stall,    32'd0);
      chk({tag, ".wb_en"},    wb_en,    32'd0);
      chk({tag, ".mult_go"},  mult_go,  32'd0);
      chk({tag, ".div_go"},   div_go,   32'd0);
      chk({tag, ".timeout"},  timeout,  exp_timeout);
      chk({tag, ".conflict"}, conflict, exp_conflict);
      tick();
   endtask

   // One full transaction. done_at / flush_at are cycle offsets from the
   // request cycle (go cycle = 1); 0 means never. Cycle TO is the last WAIT
   // cycle before the watchdog aborts.
   task automatic run_op(input string tag, input bit is_div, input bit both,
                         input logic [4:0] rg, input bit fp,
                         input logic [1:0] mm, input bit dm,
                         input int done_at, input int flush_at);
      bit   use_div;
      int   c;
      int   stall_cnt;
      int   kind;   // 0 = flushed, 1 = writeback, 2 = timed out
      bit   dn, fl;
      use_div   = is_div && !both;
      stall_cnt = 0;
      kind      = 2;
      // Request cycle
      clr_inputs();
      mult_start = !is_div || both;
      div_start  = is_div || both;
      mult_mode = mm; div_mode = dm; dest_reg = rg; dest_fp = fp;
      @(negedge clk);
      chk({tag, ".req_stall"}, stall, 32'd1);
      chk({tag, ".req_wb_en"}, wb_en, 32'd0);
      if (stall) stall_cnt++;
      tick();
      if (both) exp_conflict = 1'b1;
      // WAIT cycles
      for (c = 1; c <= TO; c++) begin
         clr_inputs();
         dest_reg = 5'($urandom); dest_fp = 1'($urandom);
         mult_mode = 2'($urandom); div_mode = 1'($urandom);
         dn = (c == done_at);
         fl = (c == flush_at);
         if (use_div) begin
            divider_done = dn; multiplier_done = 1'($urandom);
         end else begin
            multiplier_done = dn; divider_done = 1'($urandom);
         end
         flush = fl;
         @(negedge clk);
         chk({tag, ".wait_stall"}, stall, 32'd1);
         chk({tag, ".mult_go"}, mult_go, (c == 1 && !use_div) ? 32'd1 : 32'd0);
         chk({tag, ".div_go"},  div_go,  (c == 1 &&  use_div) ? 32'd1 : 32'd0);
         chk({tag, ".busy"},    busy_cycles, 32'(c - 1));
         chk({tag, ".wait_wb_en"}, wb_en, 32'd0);
         if (stall) stall_cnt++;
         tick();
         if (fl) begin kind = 0; break; end
         if (dn) begin kind = 1; break; end
      end
      if (kind == 2) begin
         c = TO;
         exp_timeout = 1'b1;
      end
      if (kind == 1) begin
         clr_inputs();
         dest_reg = 5'($urandom);
         multiplier_done = 1'($urandom); divider_done = 1'($urandom);
         flush = (flush_at == c + 1);
         @(negedge clk);
         chk({tag, ".wb_en"},  wb_en,  flush ? 32'd0 : 32'd1);
         chk({tag, ".wb_reg"}, wb_reg, rg);
         chk({tag, ".wb_fp"},  wb_fp,  fp);
         chk({tag, ".wb_sel"}, wb_sel, use_div ? 32'd1 : 32'd0);
         if (use_div) chk({tag, ".div_mode_q"},  div_mode_q,  dm);
         else         chk({tag, ".mult_mode_q"}, mult_mode_q, mm);
         chk({tag, ".wb_stall"}, stall, 32'd1);
         if (stall) stall_cnt++;
         tick();
      end
      chk({tag, ".stall_cycles"}, stall_cnt, (kind == 1) ? 32'(c + 2) : 32'(c + 1));
   endtask

   initial begin
      clr_inputs();
      mult_mode = 2'd0; div_mode = 1'b0; dest_reg = 5'd0; dest_fp = 1'b0;
      reset = 1'b0;
      tick(); tick();
      @(negedge clk);
      chk("rst.stall", stall, 32'd0);
      chk("rst.outs", {mult_go, div_go, mult_mode_q, div_mode_q, wb_en, wb_reg,
                       wb_fp, wb_sel, timeout, conflict}, 32'd0);
      chk("rst.busy", busy_cycles, 32'd0);
      reset = 1'b1;
      tick();

      // Multiply, done 3 cycles after go
      run_op("mul", 1'b0, 1'b0, 5'd5, 1'b0, 2'd2, 1'b0, 4, 0);
      check_idle("mul.idle", 1'b0);
      // Divide completing in the go cycle
      run_op("div1", 1'b1, 1'b0, 5'd30, 1'b1, 2'd1, 1'b1, 1, 0);
      check_idle("div1.idle", 1'b0);
      // Back-to-back: accept in the cycle right after WB
      run_op("b2b_a", 1'b0, 1'b0, 5'd12, 1'b1, 2'd3, 1'b0, 2, 0);
      run_op("b2b_b", 1'b1, 1'b0, 5'd17, 1'b0, 2'd0, 1'b1, 3, 0);
      check_idle("b2b.idle", 1'b0);
      // Simultaneous starts: multiply wins, conflict sticks
      run_op("conf", 1'b1, 1'b1, 5'd9, 1'b0, 2'd1, 1'b1, 2, 0);
      check_idle("conf.idle1", 1'b0);
      check_idle("conf.idle2", 1'b0);
      // Timeout with no done, late divider_done ignored
      run_op("tmo", 1'b1, 1'b0, 5'd3, 1'b1, 2'd0, 1'b0, 0, 0);
      check_idle("tmo.late1", 1'b1);
      check_idle("tmo.late2", 1'b1);
      // done on the last permitted cycle beats the watchdog
      run_op("edge", 1'b0, 1'b0, 5'd21, 1'b0, 2'd2, 1'b1, TO, 0);
      check_idle("edge.idle", 1'b0);
      // Flush 2 cycles after go, then a divide accepted immediately
      run_op("fl", 1'b0, 1'b0, 5'd7, 1'b0, 2'd1, 1'b0, 0, 3);
      check_idle("fl.idle", 1'b1);
      run_op("fl2", 1'b0, 1'b0, 5'd8, 1'b1, 2'd1, 1'b0, 5, 3);
      run_op("fl2.next", 1'b1, 1'b0, 5'd11, 1'b1, 2'd0, 1'b1, 2, 0);
      // Flush in the WB cycle kills the write
      run_op("flwb", 1'b1, 1'b0, 5'd13, 1'b0, 2'd0, 1'b0, 2, 3);
      check_idle("flwb.idle", 1'b0);
      // Flush in IDLE suppresses acceptance
      clr_inputs();
      mult_start = 1'b1; flush = 1'b1;
      @(negedge clk);
      chk("flidle.stall", stall, 32'd0);
      tick();
      check_idle("flidle.next", 1'b0);

      // Randomised transactions
      for (int i = 0; i < 24; i++) begin
         bit   rd, rb;
         int   da, fa;
         rd = 1'($urandom);
         rb = ($urandom_range(0, 9) == 0);
         da = $urandom_range(0, TO + 2);
         fa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TO + 1) : 0;
         run_op($sformatf("rnd%0d", i), rd, rb, 5'($urandom), 1'($urandom),
                2'($urandom), 1'($urandom), da, fa);
         if ($urandom_range(0, 1) == 1) check_idle($sformatf("rnd%0d.idle", i), 1'b1);
      end

      // Reset in DIV_WAIT at busy_cycles = 4, coinciding with divider_done
      clr_inputs();
      div_start = 1'b1; dest_reg = 5'd30; dest_fp = 1'b1; div_mode = 1'b1;
      tick();
      clr_inputs();
      for (int k = 0; k < 4; k++) tick();
      @(negedge clk);
      chk("mrst.busy4", busy_cycles, 32'd4);
      reset = 1'b0; divider_done = 1'b1;
      tick();
      reset = 1'b1; clr_inputs();
      exp_conflict = 1'b0; exp_timeout = 1'b0;
      @(negedge clk);
      chk("mrst.stall", stall, 32'd0);
      chk("mrst.outs", {mult_go, div_go, mult_mode_q, div_mode_q, wb_en, wb_reg,
                        wb_fp, wb_sel, timeout, conflict}, 32'd0);
      chk("mrst.busy", busy_cycles, 32'd0);
      tick();
      check_idle("mrst.idle", 1'b1);
      run_op("post", 1'b0, 1'b0, 5'd1, 1'b1, 2'd3, 1'b0, 3, 0);
      check_idle("post.idle", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
